// File: rtl/irrigation_sequencer.sv
// Tank-fed irrigation controller: IDLE/FILL/IRRIGATE/COOLDOWN/FAULT sequencer
// with a shared state timer and registered Moore outputs.
module irrigation_sequencer #(
   parameter int FILL_TIMEOUT = 1000,
   parameter int IRR_TIME     = 500,
   parameter int COOL_TIME    = 200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       LEVEL_LOW,
   input  logic       LEVEL_MID,
   input  logic       LEVEL_HIGH,
   input  logic       SOIL_DRY,
   input  logic       ACK,
   output logic       PUMP,
   output logic       VALVE_SPRINKLER,
   output logic       VALVE_DRIP,
   output logic       ALARM,
   output logic [2:0] STATE
);

   localparam int MAX_T_12  = (FILL_TIMEOUT > IRR_TIME) ? FILL_TIMEOUT : IRR_TIME;
   localparam int MAX_T     = (MAX_T_12 > COOL_TIME) ? MAX_T_12 : COOL_TIME;
   localparam int CNT_W_RAW = $clog2(MAX_T);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] IRR_LAST  = CNT_W'(IRR_TIME - 1);
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_TIME - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FILL     = 3'd1,
      ST_IRRIGATE = 3'd2,
      ST_COOLDOWN = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   // Level switches are nested; a higher mark wet with a lower one dry is a broken sensor.
   function automatic logic level_incoherent(input logic low, input logic mid, input logic high);
      return (high & ~mid) | (mid & ~low);
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             valve_sel_r;
   logic             valve_sel_next_s;
   logic             sensor_err_s;
   logic             pump_r;
   logic             sprinkler_r;
   logic             drip_r;
   logic             alarm_r;

   assign sensor_err_s = level_incoherent(LEVEL_LOW, LEVEL_MID, LEVEL_HIGH);

   // Next-state selection; a sensor error preempts every other transition.
   always_comb begin
      next_state_s = state_r;
      if (sensor_err_s && (state_r != ST_FAULT)) begin
         next_state_s = ST_FAULT;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (SOIL_DRY) begin
                  if (LEVEL_LOW) begin
                     next_state_s = ST_IRRIGATE;
                  end else begin
                     next_state_s = ST_FILL;
                  end
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_FILL: begin
               if (LEVEL_HIGH) begin
                  next_state_s = ST_IRRIGATE;
               end else if (cnt_r == FILL_LAST) begin
                  next_state_s = ST_FAULT;
               end else begin
                  next_state_s = ST_FILL;
               end
            end
            ST_IRRIGATE: begin
               if (!LEVEL_LOW) begin
                  next_state_s = ST_FILL;
               end else if (!SOIL_DRY) begin
                  next_state_s = ST_COOLDOWN;
               end else if (cnt_r == IRR_LAST) begin
                  next_state_s = ST_COOLDOWN;
               end else begin
                  next_state_s = ST_IRRIGATE;
               end
            end
            ST_COOLDOWN: begin
               if (cnt_r == COOL_LAST) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_COOLDOWN;
               end
            end
            ST_FAULT: begin
               if (ACK && !sensor_err_s) begin
                  next_state_s = ST_IDLE;
               end else begin
                  next_state_s = ST_FAULT;
               end
            end
            default: begin
               next_state_s = ST_FAULT;
            end
         endcase
      end
   end

   // Shared timer restarts on any state change and saturates otherwise.
   always_comb begin
      cnt_next_s = cnt_r;
      if (next_state_s != state_r) begin
         cnt_next_s = CNT_ZERO;
      end else if (cnt_r == CNT_MAX) begin
         cnt_next_s = cnt_r;
      end else begin
         cnt_next_s = cnt_r + CNT_ONE;
      end
   end

   // Valve choice is captured from LEVEL_MID only on the edge that enters IRRIGATE.
   always_comb begin
      valve_sel_next_s = valve_sel_r;
      if ((next_state_s == ST_IRRIGATE) && (state_r != ST_IRRIGATE)) begin
         valve_sel_next_s = LEVEL_MID;
      end else begin
         valve_sel_next_s = valve_sel_r;
      end
   end

   // State, timer, valve choice and output registers; outputs track the new state code.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         valve_sel_r <= 1'b0;
         pump_r      <= 1'b0;
         sprinkler_r <= 1'b0;
         drip_r      <= 1'b0;
         alarm_r     <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         cnt_r       <= cnt_next_s;
         valve_sel_r <= valve_sel_next_s;
         pump_r      <= (next_state_s == ST_FILL);
         sprinkler_r <= (next_state_s == ST_IRRIGATE) & valve_sel_next_s;
         drip_r      <= (next_state_s == ST_IRRIGATE) & ~valve_sel_next_s;
         alarm_r     <= (next_state_s == ST_FAULT);
      end
   end

   assign PUMP            = pump_r;
   assign VALVE_SPRINKLER = sprinkler_r;
   assign VALVE_DRIP      = drip_r;
   assign ALARM           = alarm_r;
   assign STATE           = state_r;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed self-checking bench for irrigation_sequencer with short timers
// (FILL_TIMEOUT=8, IRR_TIME=6, COOL_TIME=4).
module tb_irrigation_sequencer;

   logic       CLK;
   logic       RESET;
   logic       LEVEL_LOW;
   logic       LEVEL_MID;
   logic       LEVEL_HIGH;
   logic       SOIL_DRY;
   logic       ACK;
   logic       PUMP;
   logic       VALVE_SPRINKLER;
   logic       VALVE_DRIP;
   logic       ALARM;
   logic [2:0] STATE;

   int checks_cnt = 0;
   int errors_cnt = 0;

   // Output pattern order: {PUMP, SPRINKLER, DRIP, ALARM}
   localparam logic [3:0] O_NONE = 4'b0000;
   localparam logic [3:0] O_PUMP = 4'b1000;
   localparam logic [3:0] O_SPR  = 4'b0100;
   localparam logic [3:0] O_DRIP = 4'b0010;
   localparam logic [3:0] O_ALRM = 4'b0001;

   irrigation_sequencer #(
      .FILL_TIMEOUT (8),
      .IRR_TIME     (6),
      .COOL_TIME    (4)
   ) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .LEVEL_LOW       (LEVEL_LOW),
      .LEVEL_MID       (LEVEL_MID),
      .LEVEL_HIGH      (LEVEL_HIGH),
      .SOIL_DRY        (SOIL_DRY),
      .ACK             (ACK),
      .PUMP            (PUMP),
      .VALVE_SPRINKLER (VALVE_SPRINKLER),
      .VALVE_DRIP      (VALVE_DRIP),
      .ALARM           (ALARM),
      .STATE           (STATE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk(input string tag, input logic [2:0] exp_state, input logic [3:0] exp_outs);
      check_val({tag, ".state"}, {29'd0, STATE}, {29'd0, exp_state});
      check_val({tag, ".outs"}, {28'd0, PUMP, VALVE_SPRINKLER, VALVE_DRIP, ALARM},
                {28'd0, exp_outs});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Levels given as {HIGH, MID, LOW}
   task automatic set_lv(input logic [2:0] hml);
      LEVEL_HIGH = hml[2];
      LEVEL_MID  = hml[1];
      LEVEL_LOW  = hml[0];
   endtask

   initial begin
      RESET = 1'b1; SOIL_DRY = 1'b0; ACK = 1'b0;
      set_lv(3'b000);
      tick(); tick();
      chk("reset", 3'd0, O_NONE);
      RESET = 1'b0;
      tick(); tick();
      chk("idle_hold", 3'd0, O_NONE);

      // Full tank: irrigate on sprinkler until timeout, cool down, back to idle
      SOIL_DRY = 1'b1; set_lv(3'b111);
      for (int i = 0; i < 6; i++) begin
         tick(); chk($sformatf("irr_spr%0d", i), 3'd2, O_SPR);
      end
      for (int i = 0; i < 4; i++) begin
         tick(); chk($sformatf("cool%0d", i), 3'd3, O_NONE);
         if (i == 0) SOIL_DRY = 1'b0;
      end
      tick(); chk("cool_to_idle", 3'd0, O_NONE);

      // Empty tank: fill, levels rise at fill cycle 3, then irrigate
      SOIL_DRY = 1'b1; set_lv(3'b000);
      for (int i = 0; i < 4; i++) begin
         tick(); chk($sformatf("fill%0d", i), 3'd1, O_PUMP);
         if (i == 3) set_lv(3'b111);
      end
      tick(); chk("fill_to_irr", 3'd2, O_SPR);
      SOIL_DRY = 1'b0;
      tick(); chk("irr_wet_to_cool", 3'd3, O_NONE);
      tick(); tick(); tick();
      tick(); chk("cool_to_idle2", 3'd0, O_NONE);

      // Low level only at entry selects drip; losing LOW sends back to FILL
      SOIL_DRY = 1'b1; set_lv(3'b001);
      tick(); chk("irr_drip", 3'd2, O_DRIP);
      set_lv(3'b000);
      tick(); chk("irr_low_to_fill", 3'd1, O_PUMP);
      for (int i = 1; i < 8; i++) begin
         tick(); chk($sformatf("fill_to%0d", i), 3'd1, O_PUMP);
      end
      tick(); chk("fill_timeout", 3'd4, O_ALRM);
      ACK = 1'b1; SOIL_DRY = 1'b0;
      tick(); chk("ack_to_idle", 3'd0, O_NONE);
      ACK = 1'b0;

      // Sensor error in IRRIGATE; ACK ignored while the error persists
      SOIL_DRY = 1'b1; set_lv(3'b111);
      tick(); chk("irr_enter", 3'd2, O_SPR);
      set_lv(3'b101);
      tick(); chk("irr_sensor_err", 3'd4, O_ALRM);
      ACK = 1'b1;
      tick(); chk("ack_err_a", 3'd4, O_ALRM);
      tick(); chk("ack_err_b", 3'd4, O_ALRM);
      set_lv(3'b111); SOIL_DRY = 1'b0;
      tick(); chk("ack_clear", 3'd0, O_NONE);
      ACK = 1'b0;

      // Reset during fill cycle 5, then LEVEL_HIGH coincident with timeout
      SOIL_DRY = 1'b1; set_lv(3'b000);
      tick(); chk("fill_r0", 3'd1, O_PUMP);
      for (int i = 1; i < 6; i++) begin
         tick(); chk($sformatf("fill_r%0d", i), 3'd1, O_PUMP);
      end
      RESET = 1'b1;
      tick(); chk("reset_mid_fill", 3'd0, O_NONE);
      RESET = 1'b0;
      tick(); chk("refill0", 3'd1, O_PUMP);
      for (int i = 1; i < 8; i++) begin
         tick(); chk($sformatf("refill%0d", i), 3'd1, O_PUMP);
      end
      set_lv(3'b111);
      tick(); chk("high_beats_timeout", 3'd2, O_SPR);
      SOIL_DRY = 1'b0;
      tick(); chk("irr_to_cool3", 3'd3, O_NONE);
      tick(); tick(); tick();
      tick(); chk("cool_to_idle3", 3'd0, O_NONE);

      // Sensor error from IDLE, and reset overriding FAULT
      set_lv(3'b010);
      tick(); chk("idle_sensor_err", 3'd4, O_ALRM);
      set_lv(3'b000); ACK = 1'b1;
      tick(); chk("idle_err_ack", 3'd0, O_NONE);
      ACK = 1'b0; set_lv(3'b110);
      tick(); chk("idle_err2", 3'd4, O_ALRM);
      RESET = 1'b1;
      tick(); chk("reset_in_fault", 3'd0, O_NONE);
      RESET = 1'b0; set_lv(3'b000);
      tick(); chk("post_reset_idle", 3'd0, O_NONE);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 The block SHALL have parameter FILL_TIMEOUT, default 1000, max cycles allowed in FILL before fault.
REQ-002 The block SHALL have parameter IRR_TIME, default 500, max cycles spent in IRRIGATE per cycle.
REQ-003 The block SHALL have parameter COOL_TIME, default 200, cycles spent in COOLDOWN.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 LEVEL_LOW  input  1  tank water at or above low mark.
REQ-007 LEVEL_MID  input  1  tank water at or above mid mark.
REQ-008 LEVEL_HIGH  input  1  tank water at or above high mark.
REQ-009 SOIL_DRY  input  1  soil moisture below threshold.
REQ-010 ACK  input  1  operator fault acknowledge.
REQ-011 PUMP  output  1  tank fill pump on.
REQ-012 VALVE_SPRINKLER  output  1  sprinkler valve open.
REQ-013 VALVE_DRIP  output  1  drip valve open.
REQ-014 ALARM  output  1  fault indicator.
REQ-015 STATE  output  3  current state code.

Function
REQ-016 States and codes SHALL be IDLE=0, FILL=1, IRRIGATE=2, COOLDOWN=3, FAULT=4; codes 5-7 SHALL go to FAULT on the next edge.
REQ-017 Inputs SHALL be sampled on each rising edge; a state transition SHALL take effect on the edge at which its condition is sampled true (1 cycle latency from input change to STATE change).
REQ-018 Outputs SHALL be a Moore decode of the state register (no direct input-to-output paths).
REQ-019 Sensor error SHALL be defined as (LEVEL_HIGH & ~LEVEL_MID) | (LEVEL_MID & ~LEVEL_LOW).
REQ-020 Sensor error SHALL force FAULT from any state except FAULT, at highest priority over all other transitions.
REQ-021 IDLE: SOIL_DRY & LEVEL_LOW -> IRRIGATE; SOIL_DRY & ~LEVEL_LOW -> FILL; otherwise stay.
REQ-022 FILL: PUMP=1; LEVEL_HIGH=1 -> IRRIGATE; else cycle counter == FILL_TIMEOUT-1 -> FAULT; if both on same edge, IRRIGATE wins.
REQ-023 IRRIGATE: VALVE_SPRINKLER=LEVEL_MID-based decode latched at entry (sprinkler if LEVEL_MID=1 at the entering edge, else drip); exactly one valve open.
REQ-024 IRRIGATE exits, priority order: LEVEL_LOW=0 -> FILL; SOIL_DRY=0 -> COOLDOWN; counter == IRR_TIME-1 -> COOLDOWN.
REQ-025 COOLDOWN: all actuators off; counter == COOL_TIME-1 -> IDLE.
REQ-026 FAULT: ALARM=1, PUMP and both valves 0; ACK=1 with no sensor error -> IDLE; ACK with sensor error SHALL be ignored.
REQ-027 A single cycle counter of width clog2(max(FILL_TIMEOUT,IRR_TIME,COOL_TIME)) SHALL clear on every state transition and increment otherwise, saturating at all-ones.
REQ-028 PUMP and any valve SHALL never be 1 in the same cycle.

Reset
REQ-029 RESET=1 at a rising edge SHALL set STATE=IDLE, counter=0, valve selection=drip, and all outputs 0, overriding every other condition including mid-FILL or FAULT.
REQ-030 After RESET deasserts, normal sampling SHALL begin on the next rising edge.

Verification (FILL_TIMEOUT=8, IRR_TIME=6, COOL_TIME=4)
REQ-031 RESET 2 cycles, all inputs 0 -> STATE=0, all outputs 0, stays IDLE.
REQ-032 SOIL_DRY=1, levels all 1 -> STATE=2 next edge, VALVE_SPRINKLER=1 for 6 cycles, then STATE=3 for 4 cycles, then STATE=0.
REQ-033 SOIL_DRY=1, levels 0, LEVEL_LOW/MID/HIGH raised at fill cycle 3 -> PUMP=1 cycles 0-3, then STATE=2; LEVEL_MID=0 at entry variant -> VALVE_DRIP=1.
REQ-034 SOIL_DRY=1, levels stay 0 -> PUMP=1 for 8 cycles, then STATE=4, ALARM=1; ACK=1 -> STATE=0, ALARM=0.
REQ-035 In IRRIGATE drive LEVEL_HIGH=1, LEVEL_MID=0 -> STATE=4 next edge; ACK held with error -> stays FAULT; clear error + ACK -> IDLE.
REQ-036 RESET asserted during FILL cycle 5 -> STATE=0, PUMP=0 on that edge; LEVEL_HIGH and timeout coincident -> STATE=2, not 4.
